// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 16550-style transmit stage fed by baud_gen.
// One edge of the baud square wave `br` marks each bit period. A byte written into the
// transmit holding register (THR) is moved to the shift register (TSR) on a bit tick and
// sent LSB first with optional parity and one or two stop bits.
//
// Ports:
//   clk        system clock (same as baud_gen)
//   rst_n      asynchronous active-low reset
//   br         baud square wave, one period per bit
//   wr_en      single-cycle THR write strobe
//   wdata      byte to transmit
//   wls        word length: 00=5 .. 11=8 data bits
//   stb        0 = 1 stop bit, 1 = 2 stop bits
//   pen        parity enable
//   eps        1 = even parity, 0 = odd parity
//   brk        forces tx low while set; the frame keeps running underneath
//   tx         serial line, idle high
//   thr_empty  THR can accept a write
//   tsr_empty  THR empty and transmitter idle
module uart_tx_serializer #(
   parameter bit BR_RISE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       br,
   input  logic       wr_en,
   input  logic [7:0] wdata,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       brk,
   output logic       tx,
   output logic       thr_empty,
   output logic       tsr_empty
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StParity = 3'd3;
   localparam logic [2:0] StStop   = 3'd4;

   logic       br_q;
   logic [2:0] state_q, state_d;
   logic [7:0] thr_q, thr_d;
   logic       thr_empty_q, thr_empty_d;
   logic [7:0] tsr_q, tsr_d;
   logic       tx_q, tx_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic       par_q, par_d;
   logic [1:0] wls_q, wls_d;
   logic       stb_q, stb_d;
   logic       pen_q, pen_d;
   logic       eps_q, eps_d;
   logic       tsr_empty_q, tsr_empty_d;

   logic       tick;
   logic       stop_done;
   logic       load;
   logic [3:0] n_bits;

   assign tick   = BR_RISE ? (br & ~br_q) : (~br & br_q);
   assign n_bits = 4'd5 + {2'b00, wls_q};

   // STOP is finished unless a second stop bit is still owed
   assign stop_done = ~(stb_q & ~stop_cnt_q);
   assign load      = tick & ~thr_empty_q &
                      ((state_q == StIdle) | ((state_q == StStop) & stop_done));

   always_comb begin
      state_d     = state_q;
      thr_d       = thr_q;
      thr_empty_d = thr_empty_q;
      tsr_d       = tsr_q;
      tx_d        = tx_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      par_d       = par_q;
      wls_d       = wls_q;
      stb_d       = stb_q;
      pen_d       = pen_q;
      eps_d       = eps_q;

      // A write needs thr_empty=1 and a load needs thr_empty=0, so they never collide;
      // a write in the load cycle is dropped because it sees the pre-edge full THR.
      if (wr_en && thr_empty_q) begin
         thr_d       = wdata;
         thr_empty_d = 1'b0;
      end

      if (load) begin
         tsr_d       = thr_q;
         thr_empty_d = 1'b1;
         wls_d       = wls;
         stb_d       = stb;
         pen_d       = pen;
         eps_d       = eps;
         tx_d        = 1'b0;
         bit_cnt_d   = 4'd0;
         stop_cnt_d  = 1'b0;
         state_d     = StStart;
      end else if (tick) begin
         case (state_q)
            StIdle: begin
               tx_d = 1'b1;
            end
            StStart: begin
               tx_d      = tsr_q[0];
               tsr_d     = {1'b0, tsr_q[7:1]};
               bit_cnt_d = 4'd1;
               par_d     = tsr_q[0];
               state_d   = StData;
            end
            StData: begin
               if (bit_cnt_q < n_bits) begin
                  tx_d      = tsr_q[0];
                  tsr_d     = {1'b0, tsr_q[7:1]};
                  par_d     = par_q ^ tsr_q[0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (pen_q) begin
                  tx_d    = eps_q ? par_q : ~par_q;
                  state_d = StParity;
               end else begin
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = StStop;
               end
            end
            StParity: begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = StStop;
            end
            StStop: begin
               if (!stop_done) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = StIdle;
            end
         endcase
      end

      tsr_empty_d = thr_empty_d & (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_q        <= BR_RISE;
         state_q     <= StIdle;
         thr_q       <= 8'h00;
         thr_empty_q <= 1'b1;
         tsr_q       <= 8'h00;
         tx_q        <= 1'b1;
         bit_cnt_q   <= 4'd0;
         stop_cnt_q  <= 1'b0;
         par_q       <= 1'b0;
         wls_q       <= 2'b00;
         stb_q       <= 1'b0;
         pen_q       <= 1'b0;
         eps_q       <= 1'b0;
         tsr_empty_q <= 1'b1;
      end else begin
         br_q        <= br;
         state_q     <= state_d;
         thr_q       <= thr_d;
         thr_empty_q <= thr_empty_d;
         tsr_q       <= tsr_d;
         tx_q        <= tx_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         par_q       <= par_d;
         wls_q       <= wls_d;
         stb_q       <= stb_d;
         pen_q       <= pen_d;
         eps_q       <= eps_d;
         tsr_empty_q <= tsr_empty_d;
      end
   end

   assign tx        = tx_q & ~brk;
   assign thr_empty = thr_empty_q;
   assign tsr_empty = tsr_empty_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer.
// The model holds a THR-full flag and a queue of line levels: when a tick finds the line
// queue drained and the THR full, the whole frame (start, data, parity, stops) is
// appended using the frame settings present at that tick. Each tick pops one level.
module tb_uart_tx_serializer;

   logic       clk;
   logic       rst_n;
   logic       br;
   logic       wr_en;
   logic [7:0] wdata;
   logic [1:0] wls;
   logic       stb;
   logic       pen;
   logic       eps;
   logic       brk;
   logic       tx;
   logic       thr_empty;
   logic       tsr_empty;

   int tests;
   int fails;
   int tick_count;

   // reference model state
   logic       line;
   logic       thr_full;
   logic       tail;
   logic       br_prev;
   logic [7:0] thr_byte;
   logic       lineq[$];

   uart_tx_serializer #(
      .BR_RISE(1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .br       (br),
      .wr_en    (wr_en),
      .wdata    (wdata),
      .wls      (wls),
      .stb      (stb),
      .pen      (pen),
      .eps      (eps),
      .brk      (brk),
      .tx       (tx),
      .thr_empty(thr_empty),
      .tsr_empty(tsr_empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 16 clk per bit period
   initial begin
      br = 1'b0;
      forever begin
         repeat (8) @(negedge clk);
         br = ~br;
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   task automatic push_frame(input logic [7:0] d, input logic [1:0] w, input logic s,
                             input logic p, input logic e);
      int   n;
      logic x;
      n = 5 + int'(w);
      x = 1'b0;
      lineq.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         lineq.push_back(d[i]);
         x ^= d[i];
      end
      if (p) lineq.push_back(e ? x : ~x);
      lineq.push_back(1'b1);
      if (s) lineq.push_back(1'b1);
   endtask

   function automatic logic model_idle();
      return !thr_full && (lineq.size() == 0) && !tail;
   endfunction

   // monitor / scoreboard
   initial begin
      logic       t;
      logic       wr_s;
      logic       full_pre;
      logic [7:0] wd_s;
      logic [1:0] wls_s;
      logic       stb_s, pen_s, eps_s;
      line     = 1'b1;
      thr_full = 1'b0;
      tail     = 1'b0;
      br_prev  = 1'b1;
      thr_byte = 8'h00;
      forever begin
         @(posedge clk);
         t     = (br === 1'b1) && (br_prev === 1'b0);
         wr_s  = wr_en;
         wd_s  = wdata;
         wls_s = wls;
         stb_s = stb;
         pen_s = pen;
         eps_s = eps;
         if (!rst_n) begin
            line     = 1'b1;
            thr_full = 1'b0;
            tail     = 1'b0;
            br_prev  = 1'b1;
            lineq.delete();
         end else begin
            br_prev  = br;
            full_pre = thr_full;
            if (t) begin
               tick_count++;
               if ((lineq.size() == 0) && thr_full) begin
                  push_frame(thr_byte, wls_s, stb_s, pen_s, eps_s);
                  thr_full = 1'b0;
               end
               if (lineq.size() != 0) begin
                  line = lineq.pop_front();
                  tail = (lineq.size() == 0);
               end else begin
                  line = 1'b1;
                  tail = 1'b0;
               end
            end
            if (wr_s && !full_pre) begin
               thr_full = 1'b1;
               thr_byte = wd_s;
            end
         end
         #1;
         check("tx", tx, line & ~brk);
         check("thr_empty", thr_empty, !thr_full);
         check("tsr_empty", tsr_empty, model_idle());
      end
   end

   task automatic write_byte(input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1;
      wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic set_cfg(input logic [1:0] w, input logic s, input logic p, input logic e);
      wls = w;
      stb = s;
      pen = p;
      eps = e;
   endtask

   task automatic wait_ticks(input int n);
      int target;
      int c;
      target = tick_count + n;
      c = 0;
      while ((tick_count < target) && (c < 40 * n + 40)) begin
         @(negedge clk);
         c++;
      end
      if (tick_count < target) timeout("wait_ticks");
   endtask

   task automatic wait_loaded();
      int c;
      c = 0;
      while (thr_full && (c < 600)) begin
         @(negedge clk);
         c++;
      end
      if (thr_full) timeout("wait_loaded");
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (!model_idle() && (c < 3000)) begin
         @(negedge clk);
         c++;
      end
      if (!model_idle()) timeout("wait_idle");
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      tests      = 0;
      fails      = 0;
      tick_count = 0;
      rst_n      = 1'b0;
      wr_en      = 1'b0;
      wdata      = 8'h00;
      brk        = 1'b0;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);

      // reset, then idle for 10 bit periods
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (160) @(negedge clk);

      // 8N1, 8E1, 7O2
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      write_byte(8'hA5);
      wait_idle();
      set_cfg(2'b11, 1'b0, 1'b1, 1'b1);
      write_byte(8'hA5);
      wait_idle();
      set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
      write_byte(8'h41);
      wait_idle();

      // back-to-back frames; the 0xFF write lands while THR is full
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      write_byte(8'h55);
      wait_loaded();
      write_byte(8'h0F);
      write_byte(8'hFF);
      wait_idle();

      // mid-frame word-length change and a 3-tick break
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      write_byte(8'h96);
      wait_loaded();
      wait_ticks(2);
      wls = 2'b00;
      wait_ticks(1);
      brk = 1'b1;
      wait_ticks(3);
      brk = 1'b0;
      wait_idle();

      // async reset during data bit 3 with a second byte waiting in THR
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      write_byte(8'hC3);
      wait_loaded();
      write_byte(8'h3C);
      wait_ticks(4);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_tx_async", tx, 1'b1);
      check("rst_thr_empty", thr_empty, 1'b1);
      check("rst_tsr_empty", tsr_empty, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (64) @(negedge clk);

      // randomized frames, settings and break
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 60)) @(negedge clk);
         set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         brk = ($urandom_range(0, 9) == 0);
         write_byte(8'($urandom_range(0, 255)));
         if ((k % 8) == 7) wait_idle();
      end
      brk = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit stage directly downstream of baud_gen. It consumes the baud square wave `br` and uses each rising edge as one bit period. It holds one byte in a transmit holding register (THR) and serialises it from a transmit shift register (TSR) onto `tx`. Frame format follows 16550 LCR semantics:
- 5–8 data bits, LSB first
- optional even/odd parity
- 1 or 2 stop bits
- break control

Parameters:
BR_RISE, 1, bit-tick edge of `br`: 1 = rising edge, 0 = falling edge.

Ports:
clk        input   1  system clock, same clock that drives baud_gen
rst_n      input   1  asynchronous active-low reset
br         input   1  baud square wave from baud_gen (one period per bit)
wr_en      input   1  single-cycle write strobe for THR
wdata      input   8  byte to transmit
wls        input   2  word length: 00=5, 01=6, 10=7, 11=8 data bits
stb        input   1  0 = 1 stop bit, 1 = 2 stop bits
pen        input   1  parity enable
eps        input   1  1 = even parity, 0 = odd parity
brk        input   1  break: forces `tx` low while 1
tx         output  1  serial line, idle high
thr_empty  output  1  THR can accept a write (16550 THRE)
tsr_empty  output  1  thr_empty and FSM in IDLE (16550 TEMT)

Behaviour:
- Single clock `clk`; reset is asynchronous and active-low (`rst_n`). All state is registered on `clk`.
- Reset values:
  - tx = 1, thr_empty = 1, tsr_empty = 1
  - FSM = IDLE, bit_cnt = 0, stop_cnt = 0
  - br_d = BR_RISE, which suppresses a false tick if `br` is already high out of reset.
- Bit tick: tick = br & ~br_d (BR_RISE=1), or ~br & br_d (BR_RISE=0). br_d is `br` registered each clk. A tick lasts exactly one clk.
- THR write: accepted iff wr_en=1 and thr_empty=1 in the same cycle. THR <= wdata and thr_empty <= 0 on that edge. Writes with thr_empty=0 are dropped silently; THR is unchanged.
- Load: only on a tick in IDLE or at the end of STOP, with thr_empty=0. On that edge:
  - TSR <= THR, thr_empty <= 1
  - wls/stb/pen/eps latched into frame-config registers; mid-frame config changes have no effect
  - tx <= 0 (start bit), FSM -> START
- A write in the same cycle as a load is judged against the pre-edge thr_empty=0, so it is dropped.
- The internal tx register changes only on ticks. Transitions, all on tick:
  - IDLE: load if THR full, else tx stays 1.
  - START: tx <= TSR[0]; TSR >>= 1; bit_cnt <= 1; parity accumulator <= TSR[0]; -> DATA.
  - DATA, bit_cnt < N (N = 5 + wls_latched): tx <= TSR[0]; shift; accumulate XOR; bit_cnt++.
  - DATA, bit_cnt == N:
    - pen=1: tx <= (eps ? xor : ~xor); -> PARITY.
    - pen=0: tx <= 1; stop_cnt <= 0; -> STOP.
  - PARITY: tx <= 1; stop_cnt <= 0; -> STOP.
  - STOP:
    - stb=1 and stop_cnt=0: stop_cnt <= 1; stay (tx stays 1).
    - otherwise, THR full: load (back-to-back frame, no idle bit).
    - otherwise: -> IDLE.
- Frame length in ticks = 1 + N + pen + 1 + stb.
- Output tx = tx_reg & ~brk. Break does not pause the FSM; the frame continues underneath.
- tsr_empty = thr_empty & (FSM == IDLE), registered so it updates with the state.
- Reset asserted mid-frame: tx returns to 1 immediately (async). The frame is abandoned and THR contents are discarded.
- Between ticks no state changes, except the THR write and br_d.

Test Plan:
- Reset then idle: rst_n low 3 clk, release, toggle br 10 periods with no write -> tx=1 throughout, thr_empty=1, tsr_empty=1.
- 8N1: wls=11, pen=0, stb=0, write 0xA5 -> tx per tick 0,1,0,1,0,0,1,0,1,1 (10 ticks), then tsr_empty=1 one clk after the final tick.
- 8E1 and 7O2:
  - 0xA5, pen=1, eps=1 -> parity bit 0, 11-tick frame.
  - 0x41, wls=10, pen=1, eps=0, stb=1 -> data 1,0,0,0,0,0,1, parity 1, two stop bits, 11 ticks.
- Back-to-back and dropped write: write 0x55, then 0x0F once thr_empty=1, then 0xFF while thr_empty=0 -> 0xFF dropped; 0x0F start bit on the tick immediately after the 0x55 stop bit, no idle bit.
- Mid-frame config change and break: change wls 11->00 during DATA -> current frame keeps 8 bits. Assert brk for 3 ticks -> tx=0 for those ticks; the frame still completes on schedule.
- Async reset mid-frame: pull rst_n low during DATA bit 3 -> tx=1 without waiting for clk; thr_empty=1, and no frame resumes after release.
